sccpu_test_sequencer: RTL and testbench
=======================================

Name: sccpu_test_sequencer

Overview:
Synthesizable, parametrised test sequencer for the single-cycle CPU, generalising the single-program addi bench into a reusable self-checking harness.
- Holds the CPU in reset for a programmable number of cycles, then releases it.
- Watches the CPU data-memory write bus and compares each store, in order, against a loadable table of expected (address, data) pairs.
- Reports pass, fail with index, or timeout.
- Sits beside the sccpu instance in the top-level test wrapper; its cpu_reset output drives the sccpu reset input.

Parameters:
ADDR_W, 32, width of CPU data address bus
DATA_W, 32, width of CPU write-data bus
DEPTH, 8, number of expected-store table entries (power of 2, >=2)
RST_CYCLES, 2, cycles cpu_reset held after start
TIMEOUT, 1024, RUN-state cycle budget before timeout failure
CNT_W, 16, cycle counter width (must hold TIMEOUT)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a test run
cfg_count  in  clog2(DEPTH)+1  number of expected stores, sampled on start
exp_we  in  1  expected-table write enable
exp_idx  in  clog2(DEPTH)  table write index
exp_addr  in  ADDR_W  expected store address
exp_data  in  DATA_W  expected store data
mwmem  in  1  CPU memory write strobe
address  in  ADDR_W  CPU memory address
wdata  in  DATA_W  CPU memory write data
cpu_reset  out  1  reset to CPU
busy  out  1  high in RESET_HOLD or RUN
done  out  1  pass | fail
pass  out  1  all expected stores matched
fail  out  1  mismatch or timeout
timeout  out  1  fail caused by cycle budget
err_index  out  clog2(DEPTH)  table index of first mismatch
err_addr  out  ADDR_W  offending store address
err_data  out  DATA_W  offending store data
cycle_count  out  CNT_W  cycles spent in RUN

Behaviour:
- Async reset:
  - state=IDLE, cpu_reset=1, all other outputs 0, check pointer 0, hold counter 0.
  - Table entries cleared to 0.
- All outputs are registered. cpu_reset=1 in every state except RUN.
- States: IDLE, RESET_HOLD, RUN, PASS, FAIL.
- Table writes:
  - Accepted in IDLE, PASS and FAIL; ignored in RESET_HOLD and RUN.
  - Written value is visible on the next cycle.
- start:
  - Accepted in IDLE, PASS and FAIL; ignored while busy.
  - On accept: clear pass/fail/timeout/err_*, cycle_count=0, pointer=0, latch cfg_count (clamped to DEPTH), load hold counter=RST_CYCLES-1, go to RESET_HOLD.
  - start and exp_we in the same cycle: the write completes, and the run uses the new value.
- RESET_HOLD:
  - Hold counter decrements each cycle; cpu_reset stays 1 for exactly RST_CYCLES cycles.
  - At 0: go to RUN.
  - If the latched count is 0: go to PASS instead, CPU never released.
- RUN:
  - cycle_count increments every cycle, saturating.
  - On a cycle with mwmem=1: compare address/wdata against table[pointer].
  - Match on the last entry (pointer==count-1): go to PASS.
  - Match on any other entry: pointer++.
  - Mismatch: go to FAIL; err_index=pointer, err_addr=address, err_data=wdata.
  - Result flags are visible the cycle after the offending or final store.
  - cycle_count reaching TIMEOUT-1 with no completion: go to FAIL with timeout=1.
  - A final matching store in the same cycle as the timeout: PASS wins.
  - A mismatch in the same cycle as the timeout: mismatch error recorded, and timeout=1 as well.
- PASS/FAIL:
  - Sticky; cpu_reset=1 freezes the CPU.
  - Stores with mwmem=1 are ignored.
  - cycle_count is frozen.
- reset mid-run: immediate return to IDLE; the table is lost.

Decomposition:
- Shared header (sccpu_test_defs.vh): state encodings (3-bit localparams), RST_CYCLES/TIMEOUT defaults.
- One sub-module, sccpu_exp_table:
  - DEPTH x (ADDR_W+DATA_W) register file.
  - One synchronous write port, one combinational read port indexed by the pointer.
  - Async clear.

Test Plan:
- Reset, then start with cfg_count=0 -> cpu_reset high 2 cycles, then pass=1, done=1; cycle_count=0.
- Load table[0]=(0x4,0x5), table[1]=(0x8,0xA), cfg_count=2, start; drive stores (0x4,0x5) then (0x8,0xA) -> pass=1 the cycle after the second store, timeout=0.
- Same table; second store (0x8,0xB) -> fail=1, err_index=1, err_addr=0x8, err_data=0xB.
- cfg_count=1, no mwmem ever -> fail=1, timeout=1, cycle_count=1023.
- Assert reset mid-RUN after the first matching store -> next cycle state IDLE, cpu_reset=1, pass=fail=0; table reads 0.
- exp_we during RUN, then a rerun -> the ignored write does not alter the comparison; start while busy has no effect on the pointer.

Source files
------------

// File: rtl/sccpu_test_sequencer_pkg.sv
// Shared definitions for the single-cycle CPU test sequencer.
package sccpu_test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } seq_state_e;

    localparam int unsigned RST_CYCLES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF    = 1024;

    // Table writes and start pulses are only honoured while no run is active.
    function automatic logic accepts_cmd(input seq_state_e s);
        return (s == ST_IDLE) || (s == ST_PASS) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/sccpu_exp_table.sv
// Expected-store table: DEPTH entries of (address, data), one synchronous
// write port, one combinational read port, async clear.
module sccpu_exp_table
    import sccpu_test_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IW-1:0]     widx_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IW-1:0]     ridx_i,
    output logic [ADDR_W-1:0] raddr_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    // Entry storage; reset wipes every entry back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (we_i) begin
            addr_q[widx_i] <= waddr_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign raddr_o = addr_q[ridx_i];
    assign rdata_o = data_q[ridx_i];

endmodule

// File: rtl/sccpu_test_sequencer.sv
// Test sequencer for the single-cycle CPU: holds the CPU in reset, releases
// it, then checks each data-memory store in order against a loadable table.
module sccpu_test_sequencer
    import sccpu_test_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned IW        = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [IW:0]       cfg_count,
    input  logic              exp_we,
    input  logic [IW-1:0]     exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              mwmem,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IW-1:0]     err_index,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned       HW        = $clog2(RST_CYCLES + 1);
    localparam logic [HW-1:0]     HOLD_INIT = HW'(RST_CYCLES - 1);
    localparam logic [IW:0]       DEPTH_C   = (IW + 1)'(DEPTH);
    localparam logic [IW:0]       COUNT_ONE = (IW + 1)'(1);
    localparam logic [IW-1:0]     PTR_ONE   = IW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW:0]       count_q, count_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              tmo_q, tmo_d;
    logic [IW-1:0]     erri_q, erri_d;
    logic [ADDR_W-1:0] erra_q, erra_d;
    logic [DATA_W-1:0] errd_q, errd_d;
    logic              busy_q, done_q, cpu_rst_q;

    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic              store_hit, last_entry, to_hit;
    logic [CNT_W-1:0]  cyc_inc;

    assign tbl_we = exp_we && accepts_cmd(state_q);

    sccpu_exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .we_i    (tbl_we),
        .widx_i  (exp_idx),
        .waddr_i (exp_addr),
        .wdata_i (exp_data),
        .ridx_i  (ptr_q),
        .raddr_o (tbl_addr),
        .rdata_o (tbl_data)
    );

    assign store_hit  = (tbl_addr == address) && (tbl_data == wdata);
    assign last_entry = ({1'b0, ptr_q} == (count_q - COUNT_ONE));
    assign cyc_inc    = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
    assign to_hit     = (cyc_inc == TO_LAST);

    // Next-state and result logic; PASS/FAIL hold their results until a new start.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        erri_d  = erri_q;
        erra_d  = erra_q;
        errd_d  = errd_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d = ST_RESET_HOLD;
                    ptr_d   = '0;
                    count_d = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
                    hold_d  = HOLD_INIT;
                    cyc_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    erri_d  = '0;
                    erra_d  = '0;
                    errd_d  = '0;
                end
            end
            ST_RESET_HOLD: begin
                if (hold_q == '0) begin
                    // An empty expectation list passes without ever releasing the CPU.
                    if (count_q == '0) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_RUN: begin
                cyc_d = cyc_inc;
                if (mwmem && store_hit && last_entry) begin
                    // Completion beats a coincident timeout.
                    state_d = ST_PASS;
                    pass_d  = 1'b1;
                end else if (mwmem && !store_hit) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    tmo_d   = to_hit;
                    erri_d  = ptr_q;
                    erra_d  = address;
                    errd_d  = wdata;
                end else begin
                    if (mwmem) ptr_d = ptr_q + PTR_ONE;
                    if (to_hit) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; status flags are derived from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            cyc_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
            erri_q    <= '0;
            erra_q    <= '0;
            errd_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            cyc_q     <= cyc_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
            erri_q    <= erri_d;
            erra_q    <= erra_d;
            errd_q    <= errd_d;
            busy_q    <= (state_d == ST_RESET_HOLD) || (state_d == ST_RUN);
            done_q    <= pass_d || fail_d;
            cpu_rst_q <= (state_d != ST_RUN);
        end
    end

    assign cpu_reset   = cpu_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = tmo_q;
    assign err_index   = erri_q;
    assign err_addr    = erra_q;
    assign err_data    = errd_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_sccpu_test_sequencer.sv
// Bench for sccpu_test_sequencer: behavioural model plus per-cycle compare,
// directed scenarios with literal expectations, then randomized runs.
module tb_sccpu_test_sequencer;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 8;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 1024;
    localparam int CNT_W      = 16;
    localparam int IW         = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [IW:0]       cfg_count = '0;
    logic              exp_we = 1'b0;
    logic [IW-1:0]     exp_idx = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              mwmem = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              cpu_reset, busy, done, pass, fail, timeout;
    logic [IW-1:0]     err_index;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;
    logic [CNT_W-1:0]  cycle_count;

    sccpu_test_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cfg_count(cfg_count),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .mwmem(mwmem), .address(address), .wdata(wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .err_index(err_index), .err_addr(err_addr),
        .err_data(err_data), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Behavioural model: remaining hold cycles, a running flag, a result code
    // (0 none, 1 pass, 2 fail) and the number of stores matched so far.
    logic [ADDR_W-1:0] m_ta [DEPTH];
    logic [DATA_W-1:0] m_td [DEPTH];
    int m_n, m_hold, m_ptr, m_cyc, m_res, m_ei;
    bit m_running, m_to;
    logic [ADDR_W-1:0] m_ea;
    logic [DATA_W-1:0] m_ed;

    function automatic void m_init();
        for (int i = 0; i < DEPTH; i++) begin
            m_ta[i] = '0;
            m_td[i] = '0;
        end
        m_n = 0; m_hold = 0; m_ptr = 0; m_cyc = 0; m_res = 0; m_ei = 0;
        m_running = 1'b0; m_to = 1'b0; m_ea = '0; m_ed = '0;
    endfunction

    function automatic void m_step();
        bit tmo;
        if (m_hold == 0 && !m_running) begin
            if (exp_we) begin
                m_ta[exp_idx] = exp_addr;
                m_td[exp_idx] = exp_data;
            end
            if (start) begin
                m_n = (int'(cfg_count) > DEPTH) ? DEPTH : int'(cfg_count);
                m_hold = RST_CYCLES;
                m_res = 0; m_to = 1'b0; m_ei = 0; m_ea = '0; m_ed = '0;
                m_cyc = 0; m_ptr = 0;
            end
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                if (m_n == 0) m_res = 1;
                else m_running = 1'b1;
            end
        end else begin
            if (m_cyc < (1 << CNT_W) - 1) m_cyc++;
            tmo = (m_cyc == TIMEOUT - 1);
            if (mwmem && address == m_ta[m_ptr] && wdata == m_td[m_ptr]) begin
                if (m_ptr == m_n - 1) begin
                    m_res = 1;
                    m_running = 1'b0;
                end else begin
                    m_ptr++;
                end
            end else if (mwmem) begin
                m_res = 2; m_ei = m_ptr; m_ea = address; m_ed = wdata;
                m_to = tmo; m_running = 1'b0;
            end
            if (m_running && tmo) begin
                m_res = 2; m_to = 1'b1; m_running = 1'b0;
            end
        end
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m_init();
        else m_step();
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("cpu_reset", cpu_reset, !m_running);
            chk("busy", busy, (m_hold > 0) || m_running);
            chk("pass", pass, m_res == 1);
            chk("fail", fail, m_res == 2);
            chk("done", done, m_res != 0);
            chk("timeout", timeout, m_to);
            chk("err_index", err_index, m_ei);
            chk("err_addr", err_addr, m_ea);
            chk("err_data", err_data, m_ed);
            chk("cycle_count", cycle_count, m_cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1'b1; exp_idx = IW'(idx); exp_addr = a; exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic go(input int n);
        cfg_count = (IW + 1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mwmem = 1'b1; address = a; wdata = d;
        tick();
        mwmem = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 20 && cpu_reset; i++) tick();
        chk("run_entered", cpu_reset, 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("done_reached", done, 1);
    endtask

    task automatic wait_cycles_at(input int target);
        for (int i = 0; i < 1100 && int'(cycle_count) != target; i++) tick();
        chk("cycle_reached", cycle_count, target);
    endtask

    initial begin
        #2 reset = 1'b1;
        started = 1'b1;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick(); tick();
        reset = 1'b0;

        // Empty expectation list: two reset cycles then pass.
        go(0);
        chk("c0_hold_busy", busy, 1);
        tick();
        chk("c0_pass_early", pass, 0);
        tick();
        chk("c0_pass", pass, 1);
        chk("c0_cycles", cycle_count, 0);
        chk("c0_cpu_reset", cpu_reset, 1);

        // Two matching stores.
        load(0, 32'h4, 32'h5);
        load(1, 32'h8, 32'hA);
        go(2);
        wait_run();
        store(32'h4, 32'h5);
        chk("m2_pass_mid", pass, 0);
        store(32'h8, 32'hA);
        chk("m2_pass", pass, 1);
        chk("m2_timeout", timeout, 0);
        chk("m2_cycles", cycle_count, 2);

        // Second store mismatches.
        go(2);
        wait_run();
        store(32'h4, 32'h5);
        store(32'h8, 32'hB);
        chk("mm_fail", fail, 1);
        chk("mm_err_index", err_index, 1);
        chk("mm_err_addr", err_addr, 32'h8);
        chk("mm_err_data", err_data, 32'hB);

        // No stores at all: timeout.
        go(1);
        wait_run();
        wait_done(1100);
        chk("to_fail", fail, 1);
        chk("to_flag", timeout, 1);
        chk("to_cycles", cycle_count, 1023);

        // Final match on the timeout cycle: pass wins.
        go(1);
        wait_run();
        wait_cycles_at(1022);
        store(32'h4, 32'h5);
        chk("tp_pass", pass, 1);
        chk("tp_timeout", timeout, 0);
        chk("tp_cycles", cycle_count, 1023);

        // Mismatch on the timeout cycle: both recorded.
        go(1);
        wait_run();
        wait_cycles_at(1022);
        store(32'h4, 32'h6);
        chk("tm_fail", fail, 1);
        chk("tm_timeout", timeout, 1);
        chk("tm_err_data", err_data, 32'h6);

        // Table write and start while busy are both ignored.
        go(2);
        wait_run();
        load(1, 32'h8, 32'hB);
        store(32'h4, 32'h5);
        go(2);
        store(32'h8, 32'hA);
        chk("ig_pass", pass, 1);
        go(2);
        wait_run();
        store(32'h4, 32'h5);
        store(32'h8, 32'hA);
        chk("ig_rerun_pass", pass, 1);

        // Reset mid-run clears everything including the table.
        go(2);
        wait_run();
        store(32'h4, 32'h5);
        reset = 1'b1;
        #1;
        chk("mr_cpu_reset", cpu_reset, 1);
        chk("mr_pass", pass, 0);
        chk("mr_fail", fail, 0);
        chk("mr_busy", busy, 0);
        tick();
        reset = 1'b0;
        go(1);
        wait_run();
        store(32'h0, 32'h0);
        chk("mr_table_zero", pass, 1);

        // Randomized runs with small value ranges so matches are common.
        for (int it = 0; it < 25; it++) begin
            int nl;
            nl = int'($urandom_range(0, DEPTH));
            for (int k = 0; k < nl; k++)
                load(int'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 3), $urandom_range(0, 3));
            go(int'($urandom_range(0, 15)));
            for (int c = 0; c < 60 && !done; c++) begin
                if (m_running && $urandom_range(0, 1) == 1) begin
                    mwmem = 1'b1;
                    if ($urandom_range(0, 7) != 0) begin
                        address = m_ta[m_ptr];
                        wdata   = m_td[m_ptr];
                    end else begin
                        address = $urandom_range(0, 3);
                        wdata   = $urandom_range(0, 3);
                    end
                end
                if ($urandom_range(0, 9) == 0) begin
                    exp_we   = 1'b1;
                    exp_idx  = IW'($urandom_range(0, DEPTH - 1));
                    exp_addr = $urandom_range(0, 3);
                    exp_data = $urandom_range(0, 3);
                end
                if (m_running && $urandom_range(0, 15) == 0) begin
                    start     = 1'b1;
                    cfg_count = (IW + 1)'($urandom_range(0, 15));
                end
                tick();
                mwmem = 1'b0; exp_we = 1'b0; start = 1'b0;
            end
            wait_done(1100);
            // Stores after completion must not disturb the result.
            for (int s = 0; s < 2; s++)
                store($urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
